// File: rtl/pm_ctrl_pkg.sv
// Shared types and default constants for the phase-monitor sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: pm_state_t sweep FSM encoding, default widths and reset length.
package pm_ctrl_pkg;

  localparam int N_CH_DEF    = 4;
  localparam int PM_W_DEF    = 20;
  localparam int CNT_W_DEF   = 24;
  localparam int RST_CYC_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    ACCUM,
    CAPTURE,
    DONE
  } pm_state_t;

endpackage

// File: rtl/pm_sweep_ctrl_if.sv
// Link between the sweep controller and the phase_monitor macro.
// Latency: wires only.
// Backpressure: none; the monitor result is quasi-static and sampled when needed.
// Signals: en_pm (accumulator enable, low = reset), sel_ch (ph_in mux select),
//          sel_sign (sign config), pm_out (monitor result).
interface pm_sweep_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int PM_W  = 20,
  localparam int SEL_W = $clog2(N_CH)
);

  logic             en_pm;
  logic [SEL_W-1:0] sel_ch;
  logic [1:0]       sel_sign;
  logic [PM_W-1:0]  pm_out;

  // Controller side
  modport master (
    output en_pm,
    output sel_ch,
    output sel_sign,
    input  pm_out
  );

  // Phase monitor side
  modport slave (
    input  en_pm,
    input  sel_ch,
    input  sel_sign,
    output pm_out
  );

endinterface

// File: rtl/pm_ctrl_timer.sv
// Loadable down-counter timing the RESET and ACCUM intervals.
// Latency: load takes effect next cycle; expire is high while the count is 0.
// Backpressure: none; the counter parks at 0 until reloaded.
// Ports: clk, rst (sync, active high), load, load_val, expire.
module pm_ctrl_timer
  import pm_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load of N-1 gives exactly N cycles in the state that issued the load,
  // with expire seen in the last of them.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/pm_sweep_ctrl.sv
// Sweeps the phase monitor over a masked channel set and banks one result per channel.
// Latency: per channel RST_CYC + max(wait_cyc,1) + 1 cycles; done pulses one cycle after the last capture.
// Backpressure: none; start is ignored outside IDLE, abort drops the sweep back to IDLE.
// Ports: clk, rst (sync, active high); start/ch_mask/wait_cyc/sel_sign_cfg/abort from config space;
//        pm (master side to phase_monitor); busy, done, res_valid status; rd_addr/rd_data result read.
module pm_sweep_ctrl
  import pm_ctrl_pkg::*;
#(
  parameter  int N_CH    = N_CH_DEF,
  parameter  int PM_W    = PM_W_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int RST_CYC = RST_CYC_DEF,
  localparam int SEL_W   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [CNT_W-1:0]  wait_cyc,
  input  logic [1:0]        sel_sign_cfg,
  input  logic              abort,
  pm_sweep_ctrl_if.master   pm,
  output logic              busy,
  output logic              done,
  output logic [N_CH-1:0]   res_valid,
  input  logic [SEL_W-1:0]  rd_addr,
  output logic [PM_W-1:0]   rd_data
);

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYC - 1);

  pm_state_t        state_q, state_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       sign_q, sign_d;
  logic [SEL_W-1:0] sel_ch_q, sel_ch_d;
  logic             en_pm_q, en_pm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N_CH-1:0]  res_valid_q, res_valid_d;
  logic [PM_W-1:0]  res_q [N_CH];
  logic [PM_W-1:0]  res_d [N_CH];

  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_expire;

  logic             nxt_found, first_found;
  logic [SEL_W-1:0] nxt_ch, first_ch;
  logic [CNT_W-1:0] accum_load;

  pm_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

  // A zero window still accumulates for one cycle.
  assign accum_load = (wait_q == '0) ? '0 : (wait_q - CNT_W'(1));

  // Lowest enabled channel strictly above sel_ch (next in the sweep), and
  // lowest enabled channel of the incoming mask (first of a new sweep).
  // Scanning downwards lets the last hit be the lowest index.
  always_comb begin
    nxt_found   = 1'b0;
    nxt_ch      = '0;
    first_found = 1'b0;
    first_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(sel_ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = SEL_W'(i);
      end
      if (ch_mask[i]) begin
        first_found = 1'b1;
        first_ch    = SEL_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    wait_d      = wait_q;
    sign_d      = sign_q;
    sel_ch_d    = sel_ch_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    t_load      = 1'b0;
    t_val       = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d      = ch_mask;
          wait_d      = wait_cyc;
          sign_d      = sel_sign_cfg;
          res_valid_d = '0;
          if (first_found) begin
            state_d  = RESET;
            sel_ch_d = first_ch;
            t_load   = 1'b1;
            t_val    = RST_LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end

      RESET: begin
        if (abort) begin
          state_d = IDLE;
        end else if (t_expire) begin
          state_d = ACCUM;
          t_load  = 1'b1;
          t_val   = accum_load;
        end
      end

      ACCUM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (t_expire) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        // Abort takes priority: the in-flight channel is not banked.
        if (abort) begin
          state_d = IDLE;
        end else begin
          res_d[sel_ch_q]       = pm.pm_out;
          res_valid_d[sel_ch_q] = 1'b1;
          if (nxt_found) begin
            state_d  = RESET;
            sel_ch_d = nxt_ch;
            t_load   = 1'b1;
            t_val    = RST_LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    en_pm_d = (state_d == ACCUM) || (state_d == CAPTURE);
    busy_d  = (state_d == RESET) || (state_d == ACCUM) || (state_d == CAPTURE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      wait_q      <= '0;
      sign_q      <= '0;
      sel_ch_q    <= '0;
      en_pm_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      wait_q      <= wait_d;
      sign_q      <= sign_d;
      sel_ch_q    <= sel_ch_d;
      en_pm_q     <= en_pm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      for (int i = 0; i < N_CH; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

  assign pm.en_pm    = en_pm_q;
  assign pm.sel_ch   = sel_ch_q;
  assign pm.sel_sign = sign_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign res_valid   = res_valid_q;

  // Guard covers channel counts that are not a power of two.
  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < N_CH) begin
      rd_data = res_q[rd_addr];
    end
  end

endmodule

// File: tb/tb_pm_sweep_ctrl.sv
module tb_pm_sweep_ctrl;

  localparam int N_CH    = 4;
  localparam int PM_W    = 20;
  localparam int CNT_W   = 24;
  localparam int RST_CYC = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N_CH-1:0]  ch_mask = '0;
  logic [CNT_W-1:0] wait_cyc = '0;
  logic [1:0]       sel_sign_cfg = '0;
  logic [1:0]       rd_addr = '0;
  logic             busy, done;
  logic [N_CH-1:0]  res_valid;
  logic [PM_W-1:0]  rd_data;

  // Per-channel value the phase monitor reports when its mux points there.
  logic [PM_W-1:0]  ch_val [N_CH];

  pm_sweep_ctrl_if #(.N_CH(N_CH), .PM_W(PM_W)) pm_if ();
  assign pm_if.pm_out = ch_val[pm_if.sel_ch];

  pm_sweep_ctrl #(
    .N_CH(N_CH), .PM_W(PM_W), .CNT_W(CNT_W), .RST_CYC(RST_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ch_mask      (ch_mask),
    .wait_cyc     (wait_cyc),
    .sel_sign_cfg (sel_sign_cfg),
    .abort        (abort),
    .pm           (pm_if),
    .busy         (busy),
    .done         (done),
    .res_valid    (res_valid),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  // Scoreboard: captures (channel + cycle res_valid rises) and done cycles.
  typedef struct {
    int ch;
    int cyc;
  } cap_t;

  cap_t            exp_cap [$];
  int              exp_done [$];
  logic [PM_W-1:0] mdl_res [N_CH];
  int              t0 = 0;

  // Cycle n of a sweep (n=0 is the cycle start is sampled in) is cyc == t0+n.
  task automatic do_start(input logic [3:0] m, input int w, input logic [1:0] sg,
                          input int keep, input bit with_done);
    int p;
    int k;
    int kall;
    ch_mask      = m;
    wait_cyc     = CNT_W'(w);
    sel_sign_cfg = sg;
    start        = 1'b1;
    t0           = cyc;
    p            = RST_CYC + ((w == 0) ? 1 : w) + 1;
    k            = 0;
    kall         = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) begin
        kall++;
        if (k < keep) begin
          k++;
          exp_cap.push_back('{ch: i, cyc: t0 + k * p + 1});
          mdl_res[i] = ch_val[i];
        end
      end
    end
    if (with_done) exp_done.push_back(t0 + 1 + kall * p);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic at(input int n);
    while (cyc < t0 + n) @(negedge clk);
  endtask

  task automatic rd_chk(input int i);
    rd_addr = 2'(i);
    #1;
    chk($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(mdl_res[i]));
  endtask

  task automatic q_empty();
    chk("done_queue_left", exp_done.size(), 0);
    chk("cap_queue_left", exp_cap.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on each done pulse and each newly set valid bit.
  logic [N_CH-1:0] prev_valid = '0;
  always @(negedge clk) begin
    logic [N_CH-1:0] nw;
    cap_t e;
    if (done) begin
      if (exp_done.size() == 0) chk("done_unexpected", 32'(done), 0);
      else chk("done_cycle", cyc - t0, exp_done.pop_front() - t0);
    end
    nw = res_valid & ~prev_valid;
    for (int i = 0; i < N_CH; i++) begin
      if (nw[i]) begin
        if (exp_cap.size() == 0) begin
          chk("cap_unexpected", 32'(nw), 0);
        end else begin
          e = exp_cap.pop_front();
          chk("cap_ch", i, e.ch);
          chk("cap_cycle", cyc - t0, e.cyc - t0);
        end
      end
    end
    prev_valid = res_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ch_val[0] = 20'hAAAAA;
    ch_val[1] = 20'h55555;
    ch_val[2] = 20'h12345;
    ch_val[3] = 20'hFEDCB;
    for (int i = 0; i < N_CH; i++) mdl_res[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en_pm", 32'(pm_if.en_pm), 0);
    chk("rst_sel_ch", 32'(pm_if.sel_ch), 0);
    chk("rst_sel_sign", 32'(pm_if.sel_sign), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    rd_chk(0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two-channel sweep with sign config changed mid-sweep
    do_start(4'b0101, 10, 2'b10, 4, 1'b1);
    at(1);  chk("tc_en_pm_c1", 32'(pm_if.en_pm), 0);
            chk("tc_busy_c1", 32'(busy), 1);
            chk("tc_sel_ch_c1", 32'(pm_if.sel_ch), 0);
            chk("tc_sign_c1", 32'(pm_if.sel_sign), 2);
    at(4);  chk("tc_en_pm_c4", 32'(pm_if.en_pm), 0);
    at(5);  chk("tc_en_pm_c5", 32'(pm_if.en_pm), 1);
    at(10); sel_sign_cfg = 2'b01;
    at(15); chk("tc_en_pm_c15", 32'(pm_if.en_pm), 1);
    at(16); chk("tc_en_pm_c16", 32'(pm_if.en_pm), 0);
            chk("tc_sel_ch_c16", 32'(pm_if.sel_ch), 2);
    at(19); chk("tc_en_pm_c19", 32'(pm_if.en_pm), 0);
    at(20); chk("tc_en_pm_c20", 32'(pm_if.en_pm), 1);
    at(25); chk("tc_sign_c25", 32'(pm_if.sel_sign), 2);
    at(31); chk("tc_busy_c31", 32'(busy), 0);
            chk("tc_en_pm_c31", 32'(pm_if.en_pm), 0);
    at(33); q_empty();
            chk("tc_res_valid", 32'(res_valid), 32'h5);
            rd_chk(0);
            rd_chk(2);
    @(negedge clk);

    // Empty mask
    do_start(4'b0000, 10, 2'b00, 4, 1'b1);
    at(1);  chk("em_busy_c1", 32'(busy), 0);
            chk("em_en_pm_c1", 32'(pm_if.en_pm), 0);
            chk("em_res_valid", 32'(res_valid), 0);
    at(2);  chk("em_busy_c2", 32'(busy), 0);
    at(4);  q_empty();

    // Zero window, top channel only
    do_start(4'b1000, 0, 2'b00, 4, 1'b1);
    at(1);  chk("zw_sel_ch", 32'(pm_if.sel_ch), 3);
            chk("zw_en_pm_c1", 32'(pm_if.en_pm), 0);
    at(4);  chk("zw_en_pm_c4", 32'(pm_if.en_pm), 0);
    at(5);  chk("zw_en_pm_c5", 32'(pm_if.en_pm), 1);
    at(6);  chk("zw_en_pm_c6", 32'(pm_if.en_pm), 1);
    at(7);  chk("zw_en_pm_c7", 32'(pm_if.en_pm), 0);
            chk("zw_busy_c7", 32'(busy), 0);
    at(9);  q_empty();
            chk("zw_res_valid", 32'(res_valid), 32'h8);
            rd_chk(3);
    @(negedge clk);

    // Abort during ch1 accumulation (ch1 ACCUM spans cycles 20..29)
    do_start(4'b1111, 10, 2'b00, 1, 1'b0);
    at(22); abort = 1'b1;
    at(23); abort = 1'b0;
            chk("ab_busy", 32'(busy), 0);
            chk("ab_en_pm", 32'(pm_if.en_pm), 0);
            chk("ab_res_valid", 32'(res_valid), 32'h1);
    at(45); q_empty();
            chk("ab_res_valid_late", 32'(res_valid), 32'h1);
            rd_chk(0);
    @(negedge clk);

    // Second start during ch0 must not disturb the sweep
    do_start(4'b0001, 5, 2'b00, 4, 1'b1);
    at(3);  ch_mask = 4'b1110; wait_cyc = 24'd1; start = 1'b1;
    at(4);  start = 1'b0;
            chk("sb_sel_ch", 32'(pm_if.sel_ch), 0);
    at(11); chk("sb_busy_c11", 32'(busy), 0);
    at(13); q_empty();
            chk("sb_res_valid", 32'(res_valid), 32'h1);

    // Synchronous reset mid-sweep (ch1 in progress)
    do_start(4'b1111, 3, 2'b11, 4, 1'b1);
    at(12); chk("mr_busy_before", 32'(busy), 1);
            rst = 1'b1;
            exp_cap.delete();
            exp_done.delete();
            for (int i = 0; i < N_CH; i++) mdl_res[i] = '0;
    at(13); rst = 1'b0;
            chk("mr_en_pm", 32'(pm_if.en_pm), 0);
            chk("mr_sel_ch", 32'(pm_if.sel_ch), 0);
            chk("mr_sel_sign", 32'(pm_if.sel_sign), 0);
            chk("mr_busy", 32'(busy), 0);
            chk("mr_done", 32'(done), 0);
            chk("mr_res_valid", 32'(res_valid), 0);
            for (int i = 0; i < N_CH; i++) rd_chk(i);
    @(negedge clk);
    at(30); chk("mr_busy_late", 32'(busy), 0);
            q_empty();

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
